// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall control for the 5-stage pipeline: load-use bubbles, EX branch redirects,
// data-memory freezes and a sticky memory-wait watchdog. Define HAZARD_PERF_EN for perf counters.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ex_memtoReg,
    input  logic [4:0]        ex_rd,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_write,
    output logic              ex_mem_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              pc_sel,
    output logic              stall_active,
    output logic              mem_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_loaduse,
    output logic [PERF_W-1:0] perf_flush,
    output logic [PERF_W-1:0] perf_memwait
`endif
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    generate
        if (MEM_TIMEOUT < 1 || PERF_W < 1) begin : g_param_check
            $error("hazard_stall_ctrl: MEM_TIMEOUT and PERF_W must both be >= 1");
        end
    endgenerate

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_mem_timeout;
    logic             w_freeze;
    logic             w_load_use;
    logic [CNT_W-1:0] w_cnt_inc;

    function automatic logic src_match(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
        return uses && (rs == rd);
    endfunction

    assign w_freeze   = mem_req && !mem_ready;
    assign w_load_use = ex_memtoReg && (ex_rd != 5'd0) &&
                        (src_match(id_uses_rs1, id_rs1, ex_rd) || src_match(id_uses_rs2, id_rs2, ex_rd));
    assign w_cnt_inc  = (r_wait_cnt == CNT_MAX) ? CNT_MAX : (r_wait_cnt + CNT_ONE);
    assign mem_timeout = r_mem_timeout;

    // Pipeline controls by priority: freeze, taken branch, load-use, normal flow.
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        pc_sel       = 1'b0;
        stall_active = 1'b0;
        if (!reset) begin
            stall_active = 1'b0;
        end else if (w_freeze) begin
            stall_active = 1'b1;
        end else if (ex_branch_taken) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            pc_sel       = 1'b1;
        end else if (w_load_use) begin
            id_ex_write  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b1;
            stall_active = 1'b1;
        end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
        end
    end

    // Memory-wait FSM with saturating watchdog; the timeout flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= CNT_ZERO;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_freeze) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= CNT_ONE;
                        if (CNT_ONE == CNT_MAX) begin
                            r_mem_timeout <= 1'b1;
                        end else begin
                            r_mem_timeout <= r_mem_timeout;
                        end
                    end else begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= CNT_ZERO;
                    end
                end
                ST_MEM_WAIT: begin
                    if (w_freeze) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            r_mem_timeout <= 1'b1;
                        end else begin
                            r_mem_timeout <= r_mem_timeout;
                        end
                    end else begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= CNT_ZERO;
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= CNT_ZERO;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [PERF_W-1:0] PERF_ZERO = {PERF_W{1'b0}};
    localparam logic [PERF_W-1:0] PERF_ONE  = PERF_W'(1);

    logic              w_is_flush;
    logic              w_is_loaduse;
    logic [PERF_W-1:0] r_perf_loaduse;
    logic [PERF_W-1:0] r_perf_flush;
    logic [PERF_W-1:0] r_perf_memwait;

    assign w_is_flush   = !w_freeze && ex_branch_taken;
    assign w_is_loaduse = !w_freeze && !ex_branch_taken && w_load_use;
    assign perf_loaduse = r_perf_loaduse;
    assign perf_flush   = r_perf_flush;
    assign perf_memwait = r_perf_memwait;

    // Event counters, one per priority class that stalls or redirects the pipeline.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_loaduse <= PERF_ZERO;
            r_perf_flush   <= PERF_ZERO;
            r_perf_memwait <= PERF_ZERO;
        end else begin
            r_perf_loaduse <= w_is_loaduse ? (r_perf_loaduse + PERF_ONE) : r_perf_loaduse;
            r_perf_flush   <= w_is_flush   ? (r_perf_flush + PERF_ONE)   : r_perf_flush;
            r_perf_memwait <= w_freeze     ? (r_perf_memwait + PERF_ONE) : r_perf_memwait;
        end
    end
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline control unit for the 5-stage core. It drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Resolves three hazard classes:
  - load-use hazards, by inserting a one-cycle bubble;
  - taken branches resolved in EX, by redirecting the PC and flushing two stages;
  - multi-cycle data-memory accesses, by freezing the whole pipeline.
- Tracks memory-wait duration with a watchdog counter and raises a sticky timeout flag.

Parameters:
- MEM_TIMEOUT, 64, number of consecutive memory-wait cycles after which mem_timeout is set (must be >= 1).
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- id_rs1  input  5  rs1 index of the instruction in ID.
- id_rs2  input  5  rs2 index of the instruction in ID.
- id_uses_rs1  input  1  ID instruction reads rs1.
- id_uses_rs2  input  1  ID instruction reads rs2.
- ex_memtoReg  input  1  instruction in EX is a load (ID/EX memtoReg).
- ex_rd  input  5  destination register of the instruction in EX.
- ex_branch_taken  input  1  branch/jump in EX resolved taken this cycle.
- mem_req  input  1  instruction in MEM is issuing a data-memory access.
- mem_ready  input  1  data memory completes the access this cycle.
- pc_write  output  1  PC load enable.
- if_id_write  output  1  IF/ID load enable.
- id_ex_write  output  1  ID/EX load enable.
- ex_mem_write  output  1  EX/MEM and MEM/WB load enable.
- if_id_flush  output  1  load NOP into IF/ID.
- id_ex_flush  output  1  load bubble (all control bits 0) into ID/EX.
- pc_sel  output  1  1 = PC takes the branch target.
- stall_active  output  1  any stall or freeze this cycle.
- mem_timeout  output  1  sticky watchdog flag.

Behaviour:
- State register: RUN, MEM_WAIT. Watchdog counter wait_cnt has width $clog2(MEM_TIMEOUT+1) and saturates at MEM_TIMEOUT.
- Reset (reset==0 at a clock edge):
  - state=RUN, wait_cnt=0, mem_timeout=0.
  - While reset is low, all write enables, flushes, pc_sel and stall_active are forced to 0, so the pipeline is frozen.
- Control outputs are combinational from state and current inputs, so a hazard is acted on in the same cycle it is detected.
- freeze = mem_req && !mem_ready. This term is valid in either state.
- Output priority, highest first:
  1. freeze:
     - all *_write=0, all flushes=0, pc_sel=0, stall_active=1;
     - ex_branch_taken and load-use are ignored because EX is held and re-evaluated later.
  2. ex_branch_taken:
     - pc_sel=1, pc_write=1, if_id_flush=1, id_ex_flush=1;
     - all writes=1, stall_active=0;
     - overrides any load-use hazard, since the stalled instruction is wrong-path.
  3. load-use:
     - Condition: ex_memtoReg && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
     - pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1, ex_mem_write=1, stall_active=1.
     - The resulting bubble clears ex_memtoReg, so the stall lasts exactly one cycle.
  4. otherwise: all writes=1, flushes=0, pc_sel=0, stall_active=0.
- State transitions:
  - RUN -> MEM_WAIT when freeze; wait_cnt becomes 1.
  - MEM_WAIT stays while freeze; wait_cnt increments, saturating at MEM_TIMEOUT.
  - MEM_WAIT -> RUN when mem_ready=1 or mem_req=0; wait_cnt cleared. That exit cycle already evaluates priorities 2–4.
- Timeout:
  - When wait_cnt reaches MEM_TIMEOUT, mem_timeout is set.
  - It stays set until reset.
  - The freeze continues until mem_ready.
- Simultaneous mem_req && mem_ready in RUN: no freeze, no state change.
- Register x0 never causes a load-use stall.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, three PERF_W-bit output counters are added, each cleared on reset and wrapping at 2^PERF_W:
  - perf_loaduse: counts cycles where priority 3 applied.
  - perf_flush: counts cycles where priority 2 applied.
  - perf_memwait: counts cycles with freeze.
- When undefined, the ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Reset low for 2 cycles with random inputs -> all outputs 0. After release with idle inputs -> pc_write=if_id_write=id_ex_write=ex_mem_write=1, mem_timeout=0.
- ex_memtoReg=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1, stall_active=1. Next cycle (ex_memtoReg=0) -> normal. Repeat with ex_rd=0 -> no stall.
- Load-use hazard and ex_branch_taken=1 in the same cycle -> pc_sel=1, pc_write=1, if_id_flush=1, id_ex_flush=1, stall_active=0.
- mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> all writes 0 for 3 cycles. Exit cycle writes=1, state returns to RUN, wait_cnt=0.
- MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held for 6 cycles -> mem_timeout rises at the 4th wait cycle and stays 1 after mem_ready. Cleared only by reset.
- HAZARD_PERF_EN defined: 2 load-use stalls, 1 branch flush, 3 memwait cycles -> perf_loaduse=2, perf_flush=1, perf_memwait=3.
